// File: rtl/branch_cmp_seq.sv
// Sequential branch comparator: scans operands MSB-first, SLICE bits per clock.
// Define BRCMP_EARLY_EXIT_EN to stop at the first differing slice; otherwise all NSLC slices are visited.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// SCAN  | comparing slice idx of the registered operands
// DONE  | result valid, held until out_ready
module branch_cmp_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             illegal
);

    localparam int NSLC = WIDTH / SLICE;
    localparam int IW   = (NSLC > 1) ? $clog2(NSLC) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [IW-1:0]    idx_q,     idx_d;
    logic [WIDTH-1:0] opa_q,     opa_d;
    logic [WIDTH-1:0] opb_q,     opb_d;
    logic [2:0]       f3_q,      f3_d;
    logic             found_q,   found_d;
    logic             gt_q,      gt_d;
    logic             eq_q,      eq_d;
    logic             lt_q,      lt_d;
    logic             taken_q,   taken_d;
    logic             illegal_q, illegal_d;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic             fin;

    function automatic logic decode_taken(input logic [2:0] f, input logic eq, input logic lt);
        case (f)
            3'b000:  decode_taken = eq;
            3'b001:  decode_taken = ~eq;
            3'b100:  decode_taken = lt;
            3'b101:  decode_taken = ~lt;
            3'b110:  decode_taken = lt;
            3'b111:  decode_taken = ~lt;
            default: decode_taken = 1'b0;
        endcase
    endfunction

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign taken     = taken_q;
    assign a_gt_b    = gt_q;
    assign a_eq_b    = eq_q;
    assign a_lt_b    = lt_q;
    assign illegal   = illegal_q;

    assign a_sl = opa_q[idx_q*SLICE +: SLICE];
    assign b_sl = opb_q[idx_q*SLICE +: SLICE];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        f3_d      = f3_q;
        found_d   = found_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        fin       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    opa_d = rs1;
                    opb_d = rs2;
                    // Flipping the sign bits turns signed order into unsigned order.
                    if (!funct3[1]) begin
                        opa_d[WIDTH-1] = ~rs1[WIDTH-1];
                        opb_d[WIDTH-1] = ~rs2[WIDTH-1];
                    end
                    f3_d      = funct3;
                    idx_d     = IW'(NSLC - 1);
                    found_d   = 1'b0;
                    gt_d      = 1'b0;
                    eq_d      = 1'b0;
                    lt_d      = 1'b0;
                    taken_d   = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!found_q && (a_sl > b_sl)) begin
                    gt_d    = 1'b1;
                    found_d = 1'b1;
                end else if (!found_q && (a_sl < b_sl)) begin
                    lt_d    = 1'b1;
                    found_d = 1'b1;
                end
`ifdef BRCMP_EARLY_EXIT_EN
                fin = (idx_q == '0) || (a_sl != b_sl);
`else
                fin = (idx_q == '0);
`endif
                if (fin) begin
                    eq_d      = ~found_d;
                    taken_d   = decode_taken(f3_q, ~found_d, lt_d);
                    illegal_d = (f3_q[2:1] == 2'b01);
                    state_d   = ST_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    idx_d   = IW'(NSLC - 1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= IW'(NSLC - 1);
            opa_q     <= '0;
            opb_q     <= '0;
            f3_q      <= '0;
            found_q   <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            f3_q      <= f3_d;
            found_q   <= found_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Self-checking bench for branch_cmp_seq: directed test-plan cases, reset checks and randomized requests
// compared against an arithmetic reference model.
module tb_branch_cmp_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  funct3;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic        a_gt_b;
    logic        a_eq_b;
    logic        a_lt_b;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;

    branch_cmp_seq #(.WIDTH(32), .SLICE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken     (taken),
        .a_gt_b    (a_gt_b),
        .a_eq_b    (a_eq_b),
        .a_lt_b    (a_lt_b),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: plain signed/unsigned comparison, {gt,eq,lt}.
    function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic gt, lt;
        if (!f[1]) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return {gt, (a == b), lt};
    endfunction

    function automatic logic ref_taken(input logic [2:0] fl, input logic [2:0] f);
        case (f)
            3'b000:  return fl[1];
            3'b001:  return !fl[1];
            3'b100:  return fl[0];
            3'b101:  return !fl[0];
            3'b110:  return fl[0];
            3'b111:  return !fl[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef BRCMP_EARLY_EXIT_EN
        logic [31:0] x;
        x = a ^ b;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) return 16 - i / 2;
        end
        return 16;
`else
        return 16;
`endif
    endfunction

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f, input int hold);
        logic [2:0] ef;
        logic       et;
        logic       ei;
        int         el;
        int         lat;
        int         guard;
        ef = ref_flags(a, b, f);
        et = ref_taken(ef, f);
        ei = (f[2:1] == 2'b01);
        el = ref_lat(a, b);

        @(negedge clk);
        rs1 = a; rs2 = b; funct3 = f; in_valid = 1'b1; out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'(1));
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom_range(0, 7));
        lat = 0;
        while (!out_valid && lat < 40) begin
            chk("busy_in_ready", 32'(in_ready), 32'(0));
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            chk("done_timeout", 32'(out_valid), 32'(1));
            return;
        end
        chk("latency", 32'(lat), 32'(el));
        chk("flags", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(ef));
        chk("taken", 32'(taken), 32'(et));
        chk("illegal", 32'(illegal), 32'(ei));
        chk("hs_excl", 32'(in_ready), 32'(0));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'(1));
            chk("hold_flags", 32'({taken, illegal, a_gt_b, a_eq_b, a_lt_b}), 32'({et, ei, ef}));
            chk("hold_in_ready", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'(0));
        chk("post_in_ready", 32'(in_ready), 32'(1));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          mode;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        rs1 = '0; rs2 = '0; funct3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'({out_valid, taken, a_gt_b, a_eq_b, a_lt_b, illegal}), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", 32'(in_ready), 32'(1));

        run(32'h8000_0000, 32'h0000_0001, 3'b100, 0);
        run(32'h8000_0000, 32'h0000_0001, 3'b110, 0);
        run(32'h1234_5678, 32'h1234_5678, 3'b000, 1);
        run(32'h0001_0000, 32'h0000_0000, 3'b001, 0);
        run(32'h0000_0005, 32'h0000_0004, 3'b010, 5);
        run(32'hFFFF_FFFF, 32'h0000_0000, 3'b101, 0);
        run(32'h0000_0003, 32'h0000_0003, 3'b111, 2);

        // Reset while the equal-operand scan sits at idx 10.
        @(negedge clk);
        rs1 = 32'h1234_5678; rs2 = 32'h1234_5678; funct3 = 3'b000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready_low", 32'(in_ready), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("midrst_no_result", 32'(out_valid), 32'(0));
        end
        run(32'h0000_0000, 32'h0000_0002, 3'b100, 0);

        for (int t = 0; t < 30; t++) begin
            ra   = $urandom;
            mode = $urandom_range(0, 3);
            case (mode)
                0:       rb = ra;
                1:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                2:       rb = $urandom;
                default: rb = ra ^ ($urandom & 32'h0000_00FF);
            endcase
            run(ra, rb, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
